digit_feature_scan: RTL and testbench
=====================================

# digit_feature_scan

Parametrised successor to the single-frame digit recogniser. It binarises a streamed RGB frame into an on-chip bit map and tracks the bounding box of foreground pixels. On a `start` request it runs a sequenced raster scan that counts crossings on one vertical and two horizontal probe lines, then classifies the digit. It sits between the SD-card image loader (write side) and the display/result logic, and adds reset, a start/busy/done handshake, generic frame size and abort handling.

## Interface
- `IMG_W`, 640, frame width in pixels
- `IMG_H`, 480, frame height in pixels
- `PIX_W`, 12, RGB444 pixel width; must be 12
- `THRESH`, 8, grey level above which a pixel is background (1)
- `CNT_W`, 2, crossing-counter width; counters saturate at 2^CNT_W-1
- `ADDR_W`, derived clog2(IMG_W*IMG_H), 19 at defaults
- `CRD_W`, derived max(clog2(IMG_W), clog2(IMG_H)), 10 at defaults
- `clk_w` in 1: single clock. Reset is synchronous and active-high.
- `rst` in 1: synchronous, active-high reset.
- `w_en` in 1: pixel write strobe.
- `addr_w` in ADDR_W: raster address, y*IMG_W+x.
- `dat_w` in PIX_W: pixel {R,G,B}.
- `start` in 1: request a scan.
- `busy` out 1: scan in progress.
- `done` out 1: one-cycle pulse when results are valid.
- `left_x`, `right_x`, `up_y`, `down_y` out CRD_W: bounding box.
- `n_node` out CNT_W: vertical-line crossings.
- `m1_node_l`, `m1_node_r`, `m2_node_l`, `m2_node_r` out CNT_W: horizontal-line crossings.
- `iden_num` out 4: digit 0-9; 10 means unrecognised.

## Operation
- Binarise: grey = (4R+10G+2B)>>4 in 8-bit intermediate; bin = grey>THRESH. Foreground is 0.
- Write path is independent of the FSM: on `w_en`, store bin at addr_w.
- If addr_w==0, the box is loaded to the empty value (left=IMG_W-1, right=0, up=IMG_H-1, down=0), then updated by pixel 0 if that pixel is foreground.
- Otherwise, each foreground pixel extends the box with min/max.
- FSM states: IDLE -> CALC -> SCAN -> CLASSIFY -> IDLE.
- IDLE: accepts `start` when `w_en`=0. A `start` during `w_en` is ignored.
- CALC: one cycle. Registers n=(left+right)>>1, m1=up+(2*(down-up))/5 and m2=up+(2*(down-up))/3, using unsigned constant division. Clears all counters and sets pre=1 for each line.
- SCAN: reads addresses 0..IMG_W*IMG_H-1, one per cycle.
  - A crossing is a pre=1 to bit=0 transition along that line's own pixel sequence.
  - Vertical line: pixels with x==n.
  - Row m1/m2: the crossing is counted left if x<=n, else right.
  - All counters saturate.
- CLASSIFY: one cycle. Decodes {n,m1l,m1r,m2l,m2r} (at CNT_W=2) to iden_num using the standard table:
  - 2_1_1_1_1 -> 0; 1_1_0_1_0 -> 1; 3_0_1_1_0 -> 2; 3_0_1_0_1 -> 3; 2_1_1_1_0 -> 4; 3_1_0_0_1 -> 5
  - 3_1_0_1_1 or 3_2_0_1_1 -> 6; 2_0_1_1_0 or 2_0_1_0_1 -> 7; 3_1_1_1_1 -> 8; 3_1_1_0_1 -> 9
  - any other code -> 10
- Empty box (left>right): skip SCAN, go CALC -> CLASSIFY, report counters 0 and iden_num=10.
- `w_en` high during CALC, SCAN or CLASSIFY: abort to IDLE. No `done`; result outputs keep their previous values.

## Timing
- Reset values: all counters 0, iden_num=10, busy=0, done=0, FSM IDLE, box at the empty value. RAM contents are undefined after reset.
- busy goes high the cycle after `start` is accepted and stays high until the cycle `done` pulses, inclusive of CALC through CLASSIFY.
- RAM read latency is 1 cycle, so SCAN lasts IMG_W*IMG_H+1 cycles.
- `done` pulses exactly IMG_W*IMG_H+4 cycles after the accepting edge, or 3 cycles after it for an empty box.
- Counter, box and iden_num outputs update only on the `done` cycle and hold until the next `done` or `rst`.
- `start` while busy is ignored.

## Structure
- Package `digit_pkg`: RGB weights, the empty-box constant, the FSM state enum, and the classification table as constants.
- Sub-module `bin_frame_ram`: 1-bit × IMG_W*IMG_H, one write port and one registered read port.

## Test plan
Bench parameters: IMG_W=16, IMG_H=12. Frames are all white except where stated.
- All-white frame, start -> done at cycle 3, box left=15/right=0/up=11/down=0, iden_num=10.
- Bar x=7..8, y=2..9 -> box 7/8/2/9, n=7, m1=4, m2=6; counters 1_1_0_1_0; iden_num=1; done at 196 cycles.
- One-pixel outline x=4..11, y=2..9 -> n=7, counters 2_1_1_1_1; iden_num=0.
- Column x=7 alternating black/white rows y=0..11 -> n_node saturates at 3.
- `w_en` pulse at SCAN cycle 50 -> busy drops next cycle, no done, previous results retained.
- `rst` mid-SCAN -> next cycle all outputs at reset values, FSM IDLE.

Source files
------------

// File: rtl/digit_pkg.sv
// Shared constants for the digit recogniser: RGB weights, FSM encodings, empty-box helper and digit lookup table.
// Pure definitions, no logic of its own.
package digit_pkg;

  localparam logic [7:0] W_R = 8'd4;
  localparam logic [7:0] W_G = 8'd10;
  localparam logic [7:0] W_B = 8'd2;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_CALC     = 2'd1;
  localparam logic [1:0] ST_SCAN     = 2'd2;
  localparam logic [1:0] ST_CLASSIFY = 2'd3;

  localparam logic [3:0] DIGIT_NONE = 4'd10;

  typedef struct packed {
    logic [15:0] l;
    logic [15:0] r;
    logic [15:0] u;
    logic [15:0] d;
  } box_t;

  // Empty box is inverted (left>right) so the first foreground pixel collapses it onto itself.
  function automatic box_t empty_box(input int w, input int h);
    box_t b;
    b.l = 16'(w - 1);
    b.r = 16'd0;
    b.u = 16'(h - 1);
    b.d = 16'd0;
    return b;
  endfunction

  function automatic logic [7:0] grey_of(input logic [11:0] p);
    logic [7:0] s;
    s = W_R * {4'h0, p[11:8]} + W_G * {4'h0, p[7:4]} + W_B * {4'h0, p[3:0]};
    return s >> 4;
  endfunction

  typedef struct packed {
    logic [1:0] n;
    logic [1:0] m1l;
    logic [1:0] m1r;
    logic [1:0] m2l;
    logic [1:0] m2r;
    logic [3:0] digit;
  } cls_t;

  localparam int CLS_N = 12;
  localparam cls_t CLS_TABLE [CLS_N] = '{
    '{2'd2, 2'd1, 2'd1, 2'd1, 2'd1, 4'd0},
    '{2'd1, 2'd1, 2'd0, 2'd1, 2'd0, 4'd1},
    '{2'd3, 2'd0, 2'd1, 2'd1, 2'd0, 4'd2},
    '{2'd3, 2'd0, 2'd1, 2'd0, 2'd1, 4'd3},
    '{2'd2, 2'd1, 2'd1, 2'd1, 2'd0, 4'd4},
    '{2'd3, 2'd1, 2'd0, 2'd0, 2'd1, 4'd5},
    '{2'd3, 2'd1, 2'd0, 2'd1, 2'd1, 4'd6},
    '{2'd3, 2'd2, 2'd0, 2'd1, 2'd1, 4'd6},
    '{2'd2, 2'd0, 2'd1, 2'd1, 2'd0, 4'd7},
    '{2'd2, 2'd0, 2'd1, 2'd0, 2'd1, 4'd7},
    '{2'd3, 2'd1, 2'd1, 2'd1, 2'd1, 4'd8},
    '{2'd3, 2'd1, 2'd1, 2'd0, 2'd1, 4'd9}
  };

  // Counters arrive zero-extended so wider CNT_W builds can never alias onto a table entry.
  function automatic logic [3:0] classify(input logic [7:0] n, input logic [7:0] m1l,
                                          input logic [7:0] m1r, input logic [7:0] m2l,
                                          input logic [7:0] m2r);
    logic [3:0] res;
    res = DIGIT_NONE;
    for (int i = 0; i < CLS_N; i++) begin
      if (n == 8'(CLS_TABLE[i].n) && m1l == 8'(CLS_TABLE[i].m1l) && m1r == 8'(CLS_TABLE[i].m1r) &&
          m2l == 8'(CLS_TABLE[i].m2l) && m2r == 8'(CLS_TABLE[i].m2r))
        res = CLS_TABLE[i].digit;
    end
    return res;
  endfunction

endpackage

// File: rtl/bin_frame_ram.sv
// 1-bit frame store with one write port and one registered read port (read latency 1 cycle).
// No flow control; out-of-range writes are dropped and out-of-range reads return background.
module bin_frame_ram #(
  parameter int DEPTH  = 307200,
  parameter int ADDR_W = 19
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic              wr_bit,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_bit
);

  logic mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en && ({1'b0, wr_addr} < (ADDR_W+1)'(DEPTH)))
      mem[wr_addr] <= wr_bit;
    rd_bit <= ({1'b0, rd_addr} < (ADDR_W+1)'(DEPTH)) ? mem[rd_addr] : 1'b1;
  end

endmodule

// File: rtl/digit_feature_scan.sv
// Binarises a streamed RGB444 frame, tracks the foreground box and, on start, counts probe-line crossings
// to classify a digit; done comes IMG_W*IMG_H+4 cycles after start (3 if empty), and any write aborts a scan.
module digit_feature_scan
  import digit_pkg::*;
#(
  parameter int IMG_W  = 640,
  parameter int IMG_H  = 480,
  parameter int PIX_W  = 12,
  parameter int THRESH = 8,
  parameter int CNT_W  = 2,
  parameter int ADDR_W = $clog2(IMG_W * IMG_H),
  parameter int CRD_W  = ($clog2(IMG_W) > $clog2(IMG_H)) ? $clog2(IMG_W) : $clog2(IMG_H)
) (
  input  logic              clk_w,
  input  logic              rst,
  input  logic              w_en,
  input  logic [ADDR_W-1:0] addr_w,
  input  logic [PIX_W-1:0]  dat_w,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [CRD_W-1:0]  left_x,
  output logic [CRD_W-1:0]  right_x,
  output logic [CRD_W-1:0]  up_y,
  output logic [CRD_W-1:0]  down_y,
  output logic [CNT_W-1:0]  n_node,
  output logic [CNT_W-1:0]  m1_node_l,
  output logic [CNT_W-1:0]  m1_node_r,
  output logic [CNT_W-1:0]  m2_node_l,
  output logic [CNT_W-1:0]  m2_node_r,
  output logic [3:0]        iden_num
);

  localparam int NPIX = IMG_W * IMG_H;
  localparam box_t EMPTY = empty_box(IMG_W, IMG_H);
  localparam logic [CRD_W-1:0] EMPTY_L = CRD_W'(EMPTY.l);
  localparam logic [CRD_W-1:0] EMPTY_R = CRD_W'(EMPTY.r);
  localparam logic [CRD_W-1:0] EMPTY_U = CRD_W'(EMPTY.u);
  localparam logic [CRD_W-1:0] EMPTY_D = CRD_W'(EMPTY.d);
  localparam logic [CRD_W-1:0] X_LAST  = CRD_W'(IMG_W - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CRD_W:0]   DIV5    = (CRD_W+1)'(5);
  localparam logic [CRD_W:0]   DIV3    = (CRD_W+1)'(3);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == CNT_MAX) ? c : c + 1'b1;
  endfunction

  // Write side: binarise and grow the live bounding box.
  logic             pix_bit;
  logic [CRD_W-1:0] wx, wy;
  logic [CRD_W-1:0] box_l, box_r, box_u, box_d;
  logic [CRD_W-1:0] base_l, base_r, base_u, base_d;

  assign pix_bit = grey_of(dat_w) > 8'(THRESH);
  assign wx = CRD_W'(addr_w % ADDR_W'(IMG_W));
  assign wy = CRD_W'(addr_w / ADDR_W'(IMG_W));

  always_comb begin
    base_l = box_l;
    base_r = box_r;
    base_u = box_u;
    base_d = box_d;
    if (addr_w == '0) begin
      base_l = EMPTY_L;
      base_r = EMPTY_R;
      base_u = EMPTY_U;
      base_d = EMPTY_D;
    end
  end

  always_ff @(posedge clk_w) begin
    if (rst) begin
      box_l <= EMPTY_L;
      box_r <= EMPTY_R;
      box_u <= EMPTY_U;
      box_d <= EMPTY_D;
    end else if (w_en) begin
      box_l <= base_l;
      box_r <= base_r;
      box_u <= base_u;
      box_d <= base_d;
      if (!pix_bit) begin
        if (wx < base_l) box_l <= wx;
        if (wx > base_r) box_r <= wx;
        if (wy < base_u) box_u <= wy;
        if (wy > base_d) box_d <= wy;
      end
    end
  end

  // Scan side.
  logic [1:0]        state;
  logic [ADDR_W:0]   scan_cnt;
  logic [CRD_W-1:0]  sx, sy, px, py;
  logic              pv;
  logic              rd_bit;
  logic [CRD_W-1:0]  n_pos, m1_pos, m2_pos;
  logic [CRD_W-1:0]  n_calc, m1_calc, m2_calc;
  logic [CRD_W:0]    sum_lr, span2;
  logic              pre_v, pre_1, pre_2;
  logic [CNT_W-1:0]  c_n, c_1l, c_1r, c_2l, c_2r;
  logic              empty_run;

  assign sum_lr  = {1'b0, box_l} + {1'b0, box_r};
  assign n_calc  = CRD_W'(sum_lr >> 1);
  assign span2   = {box_d - box_u, 1'b0};
  assign m1_calc = box_u + CRD_W'(span2 / DIV5);
  assign m2_calc = box_u + CRD_W'(span2 / DIV3);
  assign busy    = (state != ST_IDLE);

  bin_frame_ram #(
    .DEPTH  (NPIX),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk_w),
    .wr_en   (w_en),
    .wr_addr (addr_w),
    .wr_bit  (pix_bit),
    .rd_addr (scan_cnt[ADDR_W-1:0]),
    .rd_bit  (rd_bit)
  );

  always_ff @(posedge clk_w) begin
    if (rst) begin
      state     <= ST_IDLE;
      done      <= 1'b0;
      scan_cnt  <= '0;
      sx        <= '0;
      sy        <= '0;
      px        <= '0;
      py        <= '0;
      pv        <= 1'b0;
      n_pos     <= '0;
      m1_pos    <= '0;
      m2_pos    <= '0;
      pre_v     <= 1'b1;
      pre_1     <= 1'b1;
      pre_2     <= 1'b1;
      c_n       <= '0;
      c_1l      <= '0;
      c_1r      <= '0;
      c_2l      <= '0;
      c_2r      <= '0;
      empty_run <= 1'b0;
      left_x    <= EMPTY_L;
      right_x   <= EMPTY_R;
      up_y      <= EMPTY_U;
      down_y    <= EMPTY_D;
      n_node    <= '0;
      m1_node_l <= '0;
      m1_node_r <= '0;
      m2_node_l <= '0;
      m2_node_r <= '0;
      iden_num  <= DIGIT_NONE;
    end else begin
      done <= 1'b0;
      pv   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start && !w_en) state <= ST_CALC;
        end
        ST_CALC: begin
          if (w_en) begin
            state <= ST_IDLE;
          end else begin
            n_pos     <= n_calc;
            m1_pos    <= m1_calc;
            m2_pos    <= m2_calc;
            c_n       <= '0;
            c_1l      <= '0;
            c_1r      <= '0;
            c_2l      <= '0;
            c_2r      <= '0;
            pre_v     <= 1'b1;
            pre_1     <= 1'b1;
            pre_2     <= 1'b1;
            scan_cnt  <= '0;
            sx        <= '0;
            sy        <= '0;
            empty_run <= (box_l > box_r);
            state     <= (box_l > box_r) ? ST_CLASSIFY : ST_SCAN;
          end
        end
        ST_SCAN: begin
          if (w_en) begin
            state <= ST_IDLE;
          end else begin
            // Issue one read per cycle; the extra final cycle drains the last read.
            if (scan_cnt != (ADDR_W+1)'(NPIX)) begin
              pv <= 1'b1;
              px <= sx;
              py <= sy;
              if (sx == X_LAST) begin
                sx <= '0;
                sy <= sy + 1'b1;
              end else begin
                sx <= sx + 1'b1;
              end
            end else begin
              state <= ST_CLASSIFY;
            end
            scan_cnt <= scan_cnt + 1'b1;
            if (pv) begin
              if (px == n_pos) begin
                if (pre_v && !rd_bit) c_n <= sat_inc(c_n);
                pre_v <= rd_bit;
              end
              if (py == m1_pos) begin
                if (pre_1 && !rd_bit) begin
                  if (px <= n_pos) c_1l <= sat_inc(c_1l);
                  else             c_1r <= sat_inc(c_1r);
                end
                pre_1 <= rd_bit;
              end
              if (py == m2_pos) begin
                if (pre_2 && !rd_bit) begin
                  if (px <= n_pos) c_2l <= sat_inc(c_2l);
                  else             c_2r <= sat_inc(c_2r);
                end
                pre_2 <= rd_bit;
              end
            end
          end
        end
        ST_CLASSIFY: begin
          state <= ST_IDLE;
          if (!w_en) begin
            done      <= 1'b1;
            left_x    <= box_l;
            right_x   <= box_r;
            up_y      <= box_u;
            down_y    <= box_d;
            n_node    <= c_n;
            m1_node_l <= c_1l;
            m1_node_r <= c_1r;
            m2_node_l <= c_2l;
            m2_node_r <= c_2r;
            iden_num  <= empty_run ? DIGIT_NONE
                                   : classify(8'(c_n), 8'(c_1l), 8'(c_1r), 8'(c_2l), 8'(c_2r));
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_digit_feature_scan.sv
// Directed bench for digit_feature_scan on a 16x12 frame with a result scoreboard.
module tb_digit_feature_scan;

  localparam int W = 16;
  localparam int H = 12;
  localparam int N = W * H;

  logic       clk_w = 1'b0;
  logic       rst = 1'b1;
  logic       w_en = 1'b0;
  logic [7:0] addr_w = '0;
  logic [11:0] dat_w = '0;
  logic       start = 1'b0;
  logic       busy, done;
  logic [3:0] left_x, right_x, up_y, down_y;
  logic [1:0] n_node, m1_node_l, m1_node_r, m2_node_l, m2_node_r;
  logic [3:0] iden_num;

  typedef struct {
    int l, r, u, d, n, a, b, c, e, id, lat;
  } exp_t;

  exp_t        sb[$];
  exp_t        last_exp;
  logic [11:0] pix [N];
  logic [11:0] blacks [4] = '{12'h000, 12'h0D0, 12'hF0F, 12'h333};
  logic [11:0] whites [3] = '{12'hFFF, 12'h0F0, 12'hAAA};
  int          n_chk = 0;
  int          n_pass = 0;

  digit_feature_scan #(.IMG_W(W), .IMG_H(H)) dut (
    .clk_w(clk_w), .rst(rst), .w_en(w_en), .addr_w(addr_w), .dat_w(dat_w), .start(start),
    .busy(busy), .done(done), .left_x(left_x), .right_x(right_x), .up_y(up_y), .down_y(down_y),
    .n_node(n_node), .m1_node_l(m1_node_l), .m1_node_r(m1_node_r),
    .m2_node_l(m2_node_l), .m2_node_r(m2_node_r), .iden_num(iden_num)
  );

  always #5 clk_w = ~clk_w;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    assert (obs === exp_v) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
  endtask

  function automatic bit is_bg(input logic [11:0] p);
    int g;
    g = (4 * p[11:8] + 10 * p[7:4] + 2 * p[3:0]) >> 4;
    return g > 8;
  endfunction

  function automatic int sat(input int v);
    return (v < 3) ? v + 1 : 3;
  endfunction

  function automatic int classify_ref(input int n, input int a, input int b, input int c, input int e);
    logic [9:0] code;
    code = {2'(n), 2'(a), 2'(b), 2'(c), 2'(e)};
    case (code)
      10'b10_01_01_01_01: return 0;
      10'b01_01_00_01_00: return 1;
      10'b11_00_01_01_00: return 2;
      10'b11_00_01_00_01: return 3;
      10'b10_01_01_01_00: return 4;
      10'b11_01_00_00_01: return 5;
      10'b11_01_00_01_01: return 6;
      10'b11_10_00_01_01: return 6;
      10'b10_00_01_01_00: return 7;
      10'b10_00_01_00_01: return 7;
      10'b11_01_01_01_01: return 8;
      10'b11_01_01_00_01: return 9;
      default:            return 10;
    endcase
  endfunction

  function automatic exp_t empty_exp();
    exp_t e;
    e = '{l: W-1, r: 0, u: H-1, d: 0, n: 0, a: 0, b: 0, c: 0, e: 0, id: 10, lat: 3};
    return e;
  endfunction

  function automatic exp_t model();
    exp_t e;
    int   n, m1, m2, pv, p1, p2;
    bit   bg;
    e = empty_exp();
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        if (!is_bg(pix[y*W+x])) begin
          if (x < e.l) e.l = x;
          if (x > e.r) e.r = x;
          if (y < e.u) e.u = y;
          if (y > e.d) e.d = y;
        end
    if (e.l > e.r) return e;
    n  = (e.l + e.r) / 2;
    m1 = e.u + (2 * (e.d - e.u)) / 5;
    m2 = e.u + (2 * (e.d - e.u)) / 3;
    pv = 1; p1 = 1; p2 = 1;
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) begin
        bg = is_bg(pix[y*W+x]);
        if (x == n) begin
          if (pv != 0 && !bg) e.n = sat(e.n);
          pv = int'(bg);
        end
        if (y == m1) begin
          if (p1 != 0 && !bg) begin
            if (x <= n) e.a = sat(e.a); else e.b = sat(e.b);
          end
          p1 = int'(bg);
        end
        if (y == m2) begin
          if (p2 != 0 && !bg) begin
            if (x <= n) e.c = sat(e.c); else e.e = sat(e.e);
          end
          p2 = int'(bg);
        end
      end
    e.id  = classify_ref(e.n, e.a, e.b, e.c, e.e);
    e.lat = N + 4;
    return e;
  endfunction

  task automatic cmp_results(input string tag, input exp_t e);
    chk({tag, "_left"},  32'(left_x),    e.l);
    chk({tag, "_right"}, 32'(right_x),   e.r);
    chk({tag, "_up"},    32'(up_y),      e.u);
    chk({tag, "_down"},  32'(down_y),    e.d);
    chk({tag, "_n"},     32'(n_node),    e.n);
    chk({tag, "_m1l"},   32'(m1_node_l), e.a);
    chk({tag, "_m1r"},   32'(m1_node_r), e.b);
    chk({tag, "_m2l"},   32'(m2_node_l), e.c);
    chk({tag, "_m2r"},   32'(m2_node_r), e.e);
    chk({tag, "_iden"},  32'(iden_num),  e.id);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    cmp_results(tag, empty_exp());
  endtask

  task automatic write_frame(input bit poke_start);
    for (int a = 0; a < N; a++) begin
      @(negedge clk_w);
      if (poke_start && a == 101) chk("start_during_wen_busy", 32'(busy), 0);
      w_en   = 1'b1;
      addr_w = 8'(a);
      dat_w  = pix[a];
      start  = poke_start && (a == 100);
    end
    @(negedge clk_w);
    w_en  = 1'b0;
    start = 1'b0;
  endtask

  // Drives start, queues the expectation, then pops it when done appears; also pokes start mid-scan.
  task automatic run_scan(input string tag, input exp_t e_in);
    exp_t e;
    int   cyc;
    sb.push_back(e_in);
    @(negedge clk_w);
    start = 1'b1;
    @(negedge clk_w);
    start = 1'b0;
    cyc = 1;
    chk({tag, "_busy_calc"}, 32'(busy), 1);
    while (done !== 1'b1 && cyc < 400) begin
      start = (cyc == 10);
      @(negedge clk_w);
      cyc++;
    end
    start = 1'b0;
    e = sb.pop_front();
    chk({tag, "_done_cycle"}, 32'(cyc), e.lat);
    cmp_results(tag, e);
    last_exp = e;
    @(negedge clk_w);
    chk({tag, "_done_pulse"}, 32'(done), 0);
    chk({tag, "_busy_after"}, 32'(busy), 0);
  endtask

  task automatic fill_white();
    for (int i = 0; i < N; i++) pix[i] = whites[i % 3];
  endtask

  initial begin
    bit seen;
    repeat (3) @(negedge clk_w);
    chk_reset("reset");
    rst = 1'b0;

    fill_white();
    write_frame(1'b1);
    run_scan("white", model());

    fill_white();
    for (int y = 2; y <= 9; y++)
      for (int x = 7; x <= 8; x++) pix[y*W+x] = blacks[(x + y) % 4];
    write_frame(1'b0);
    run_scan("bar", model());

    fill_white();
    for (int y = 2; y <= 9; y++)
      for (int x = 4; x <= 11; x++)
        if (x == 4 || x == 11 || y == 2 || y == 9) pix[y*W+x] = blacks[(x * 3 + y) % 4];
    write_frame(1'b0);
    run_scan("outline", model());

    fill_white();
    for (int y = 0; y < H; y += 2) pix[y*W+7] = blacks[y % 4];
    write_frame(1'b0);
    run_scan("column", model());

    for (int i = 0; i < N; i++)
      pix[i] = ($urandom_range(0, 7) == 0) ? 12'($urandom_range(0, 4095)) : whites[i % 3];
    write_frame(1'b0);
    run_scan("random", model());

    // Abort at SCAN cycle 50 with a harmless rewrite of a non-zero address.
    @(negedge clk_w);
    start = 1'b1;
    @(negedge clk_w);
    start = 1'b0;
    for (int c = 1; c < 51; c++) @(negedge clk_w);
    w_en = 1'b1;
    addr_w = 8'd5;
    dat_w = pix[5];
    @(negedge clk_w);
    w_en = 1'b0;
    chk("abort_busy", 32'(busy), 0);
    seen = 1'b0;
    for (int c = 0; c < 250; c++) begin
      @(negedge clk_w);
      if (done === 1'b1) seen = 1'b1;
    end
    chk("abort_no_done", 32'(seen), 0);
    cmp_results("abort_hold", last_exp);

    // Synchronous reset in the middle of a scan.
    @(negedge clk_w);
    start = 1'b1;
    @(negedge clk_w);
    start = 1'b0;
    for (int c = 1; c < 40; c++) @(negedge clk_w);
    rst = 1'b1;
    @(negedge clk_w);
    chk_reset("midscan_rst");
    rst = 1'b0;
    run_scan("post_rst", empty_exp());

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
